// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer
//   Drives the J/K pins of a bank of WIDTH external JK flip-flops that share
//   `clock`. One command at a time is accepted over a valid/ready handshake
//   and turned into per-bit J/K patterns: clear, parallel load, or count
//   up/down for a programmed number of clocks. Counting reads the live bank
//   outputs `q`, so each toggle decision uses the value present in the same
//   cycle.
//
// Ports
//   clock      rising-edge clock, shared with the flop bank
//   resetn     synchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  controller can accept a command
//   cmd_op     00 clear, 01 load, 10 count up, 11 count down
//   cmd_data   load value (op 01 only)
//   cmd_steps  clock count for ops 10/11 (0 completes with no J/K activity)
//   q          Q outputs fed back from the bank
//   j, k       J/K inputs of each flop (combinational)
//   busy       command in progress
//   done       one-cycle completion pulse
module jk_bank_sequencer #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STEP_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_data,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  j,
  output logic [WIDTH-1:0]  k,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_CLR  = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } op_t;

  state_t             state;
  op_t                op_r;
  logic [WIDTH-1:0]   data_r;
  logic [STEP_W-1:0]  cnt;

  logic [WIDTH-1:0]   tog_up;
  logic [WIDTH-1:0]   tog_dn;

  // Control path. cmd_ready/busy/done are registered; cmd_ready is held low
  // for the reset edge and rises one edge after release.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      op_r      <= OP_CLR;
      data_r    <= '0;
      cnt       <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            op_r      <= op_t'(cmd_op);
            data_r    <= cmd_data;
            cnt       <= cmd_steps;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            // A zero-length count finishes without ever driving the bank.
            if (cmd_op[1] && (cmd_steps == '0)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= EXEC;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        EXEC: begin
          // Clear/load last one cycle; counts leave when the counter reads 1,
          // giving exactly cmd_steps toggle cycles.
          if (!op_r[1] || (cnt == STEP_W'(1))) begin
            state <= DONE;
            done  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt - STEP_W'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

  // Ripple toggle enables: bit i toggles when all lower bits are 1 (up) or
  // all lower bits are 0 (down). Running AND avoids a self-referencing vector.
  always_comb begin
    logic run_up;
    logic run_dn;
    tog_up = '0;
    tog_dn = '0;
    run_up = 1'b1;
    run_dn = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      tog_up[i] = run_up;
      tog_dn[i] = run_dn;
      run_up    = run_up & q[i];
      run_dn    = run_dn & ~q[i];
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    if (state == EXEC) begin
      case (op_r)
        OP_CLR: begin
          j = '0;
          k = '1;
        end
        OP_LOAD: begin
          j = data_r;
          k = ~data_r;
        end
        OP_UP: begin
          j = tog_up;
          k = tog_up;
        end
        OP_DOWN: begin
          j = tog_dn;
          k = tog_dn;
        end
        default: begin
          j = '0;
          k = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
module tb_jk_bank_sequencer;

  localparam int unsigned W = 4;
  localparam int unsigned S = 8;

  logic          clock = 1'b0;
  logic          resetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic [S-1:0]  cmd_steps;
  logic [W-1:0]  bank;
  logic [W-1:0]  j;
  logic [W-1:0]  k;
  logic          busy;
  logic          done;

  logic          preset_en;
  logic [W-1:0]  preset_val;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  mdl;

  always #5 clock = ~clock;

  jk_bank_sequencer #(.WIDTH(W), .STEP_W(S)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_steps (cmd_steps),
    .q         (bank),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done)
  );

  // External JK flip-flop bank; preset only used to seed it during reset.
  always @(posedge clock) begin
    if (preset_en) begin
      bank <= preset_val;
    end else begin
      for (int i = 0; i < int'(W); i++) begin
        case ({j[i], k[i]})
          2'b10:   bank[i] <= 1'b1;
          2'b01:   bank[i] <= 1'b0;
          2'b11:   bank[i] <= ~bank[i];
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] next_val(input logic [1:0] op, input logic [W-1:0] cur,
                                            input logic [W-1:0] d);
    case (op)
      2'b00:   return '0;
      2'b01:   return d;
      2'b10:   return cur + W'(1);
      default: return cur - W'(1);
    endcase
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] d,
                         input int unsigned steps, input bit glitch);
    int unsigned  n_exec;
    int unsigned  cycles;
    logic [W-1:0] cur;
    logic [W-1:0] ej;
    logic [W-1:0] ek;
    bit           prev_exec;
    bit           seen;

    n_exec = op[1] ? steps : 1;
    cur = mdl;
    for (int unsigned i = 0; i < n_exec; i++) begin
      cur = next_val(op, cur, d);
      exp_q.push_back(cur);
    end

    @(negedge clock);
    cmd_op    = op;
    cmd_data  = d;
    cmd_steps = S'(steps);
    cmd_valid = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (cmd_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!seen) begin
      check("accept_timeout", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
      exp_q.delete();
      return;
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_data  = ~d;
    cmd_steps = ~S'(steps);

    cur = mdl;
    prev_exec = 1'b0;
    seen = 1'b0;
    cycles = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clock);
      cmd_valid = 1'b0;
      cycles++;
      if (prev_exec) begin
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        check("bank", {28'd0, bank}, {28'd0, cur});
      end
      check("busy", {31'd0, busy}, 32'd1);
      check("ready_busy", {31'd0, cmd_ready}, 32'd0);
      if (done) begin
        seen = 1'b1;
        break;
      end
      prev_exec = 1'b1;
      case (op)
        2'b00:   begin ej = '0; ek = '1; end
        2'b01:   begin ej = d;  ek = ~d; end
        2'b10:   begin ej = cur ^ (cur + W'(1)); ek = ej; end
        default: begin ej = cur ^ (cur - W'(1)); ek = ej; end
      endcase
      check("j", {28'd0, j}, {28'd0, ej});
      check("k", {28'd0, k}, {28'd0, ek});
      if (glitch && cycles == 1) begin
        cmd_op    = 2'b01;
        cmd_data  = ~cur;
        cmd_steps = 8'd1;
        cmd_valid = 1'b1;
      end
    end
    if (!seen) check("done_timeout", {31'd0, done}, 32'd1);
    check("cycles", cycles, n_exec + 1);
    check("bank_at_done", {28'd0, bank}, {28'd0, cur});
    check("jk_at_done", {24'd0, j, k}, 32'd0);
    check("queue_left", exp_q.size(), 32'd0);
    exp_q.delete();
    mdl = cur;

    @(negedge clock);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("ready_after", {31'd0, cmd_ready}, 32'd1);
    check("hold", {28'd0, bank}, {28'd0, mdl});
    check("jk_idle", {24'd0, j, k}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_data   = '0;
    cmd_steps  = '0;
    preset_en  = 1'b1;
    preset_val = 4'b1010;

    // Reset with the bank sitting at 1010.
    @(negedge clock);
    preset_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      check("rst_ready", {31'd0, cmd_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_jk", {24'd0, j, k}, 32'd0);
      check("rst_bank", {28'd0, bank}, 32'hA);
    end
    resetn = 1'b1;
    @(negedge clock);
    check("rel_ready", {31'd0, cmd_ready}, 32'd1);
    mdl = 4'b1010;

    run_cmd(2'b00, 4'b0000, 0, 1'b0);   // clear from 1010
    run_cmd(2'b01, 4'b0110, 0, 1'b0);   // load 0110
    run_cmd(2'b01, 4'b1101, 0, 1'b0);
    run_cmd(2'b10, 4'b0000, 5, 1'b0);   // up 5 from 1101, wraps
    run_cmd(2'b01, 4'b0001, 0, 1'b0);
    run_cmd(2'b11, 4'b0000, 3, 1'b1);   // down 3 from 0001, valid pulsed while busy
    run_cmd(2'b10, 4'b0000, 0, 1'b0);   // zero steps

    // Reset asserted during the second EXEC cycle of up-6 from 0000.
    run_cmd(2'b00, 4'b0000, 0, 1'b0);
    check("mid_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_op    = 2'b10;
    cmd_data  = '0;
    cmd_steps = 8'd6;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b0;
    mdl = next_val(2'b10, next_val(2'b10, mdl, '0), '0);
    @(posedge clock);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("abort_bank", {28'd0, bank}, {28'd0, mdl});
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_ready", {31'd0, cmd_ready}, 32'd0);
      check("abort_jk", {24'd0, j, k}, 32'd0);
    end
    resetn = 1'b1;
    @(negedge clock);
    check("abort_rel_ready", {31'd0, cmd_ready}, 32'd1);
    check("abort_rel_bank", {28'd0, bank}, {28'd0, mdl});
    run_cmd(2'b10, 4'b0000, 1, 1'b0);   // recovers: 0010 -> 0011

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
